serial_beacon_echo: RTL
=======================

// Module: serial_beacon_echo
// PURPOSE
//  Byte source/sink for the usb_uart valid/ready pipelines. Combines a periodic
//  fixed-message beacon with a buffered loopback echo of host-received bytes.
//  Mode selects idle, beacon, echo or both. Sits between top-level board glue
//  and usb_uart, in place of single-character test senders.
// PARAMETERS
//  MSG_LEN      4          bytes in beacon message (1..16)
//  MSG          "OK\r\n"   packed message, MSG[8*MSG_LEN-1 -: 8] sent first
//  DELAY_WIDTH  20         inter-message gap = 2**DELAY_WIDTH clk cycles
//  FIFO_DEPTH   8          echo buffer entries, power of two >= 2
//  ECHO_UPPER   0          1: echoed 'a'..'z' converted to 'A'..'Z'
// PORTS
//  clk_48mhz       in   1  system clock
//  reset           in   1  async active-high reset
//  mode            in   2  00 idle, 01 beacon, 10 echo, 11 beacon+echo
//  uart_in_data    out  8  byte to usb_uart transmit pipeline
//  uart_in_valid   out  1  uart_in_data valid
//  uart_in_ready   in   1  usb_uart accepts byte
//  uart_out_data   in   8  byte received from host
//  uart_out_valid  in   1  uart_out_data valid
//  uart_out_ready  out  1  block accepts received byte
//  msg_done        out  1  1-cycle pulse: last beacon byte accepted
//  busy            out  1  beacon message in progress or FIFO non-empty
// BEHAVIOUR
//  Reset (async): uart_in_valid=0, uart_in_data=0, msg_done=0, busy=0, FIFO empty,
//   delay counter=0, state IDLE. uart_out_ready is combinational and also 0 in reset.
//  Handshake: transfer on valid&&ready at posedge. Once valid is high, data and
//   valid hold until accepted. Output register reloads in the accept cycle, so
//   back-to-back bytes keep valid high (1 byte/clk max).
//  Rx side: mode[1]=1 -> uart_out_ready = !fifo_full, byte written on handshake.
//   mode[1]=0 -> uart_out_ready=1, bytes discarded (host never stalls).
//  FSM:
//   IDLE: mode[0]=1 -> MSG (idx=0); else if FIFO non-empty -> ECHO.
//   MSG:  present MSG[idx]; on accept idx++. On accepting idx=MSG_LEN-1:
//         pulse msg_done, clear counter -> WAIT.
//   WAIT: counter++ each cycle. When counter wraps to 0 -> IDLE.
//         Echo bytes may be sent during WAIT.
//   ECHO: pop FIFO head into the output register (conversion per ECHO_UPPER).
//         On accept -> IDLE.
//  Priority in IDLE: beacon over echo. A started message is atomic; echo bytes are
//   never interleaved inside a message.
//  First message after reset starts immediately if mode[0]=1 (no initial gap).
//  Mode change mid-message: message completes, and the new mode applies at next IDLE.
//   mode[0] cleared during WAIT: WAIT completes, then no new message.
//   mode[1] cleared: bytes already buffered are still echoed.
//  FIFO latency: a byte written at edge T may appear on uart_in_valid at T+1 at
//   the earliest. Simultaneous push+pop when full is legal; push is blocked only
//   via uart_out_ready.
//  Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
//   full = MSB differ && rest equal; empty = equal.
//  busy = (state==MSG) || !fifo_empty, registered.
// STRUCTURE
//  Package serial_pkg: FSM state encodings (IDLE, MSG, WAIT, ECHO), mode
//   encodings, ASCII constants ('a', 'z', case offset 8'h20).
//  Sub-module sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH): push/pop, full/empty, same
//   reset; first-word-fall-through head.
//  Top holds FSM, message index, delay counter and output register.
// TESTING
//  mode=01, DELAY_WIDTH=4, ready=1 -> "O","K",CR,LF on 4 consecutive clks,
//   msg_done once, next 'O' exactly 16 clks later.
//  mode=01, ready toggled 1/0 randomly -> byte stream unchanged;
//   data stable while valid&&!ready.
//  mode=10, ECHO_UPPER=1, host sends "aZ!" -> out "AZ!" in order;
//   ready stays low -> after 8 bytes uart_out_ready=0, no byte lost.
//  mode=11, host sends 'x' during MSG -> 'x' emitted after LF, before next 'O'.
//  reset asserted mid-message after 2 bytes -> valid=0 asynchronously;
//   after release, message restarts at 'O'.
//  mode=00 -> uart_out_ready=1, no uart_in_valid ever, busy=0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the beacon/echo byte source.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MSG  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ECHO = 2'd3
    } state_t;

    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_BEACON = 2'b01;
    localparam logic [1:0] MODE_ECHO   = 2'b10;
    localparam logic [1:0] MODE_BOTH   = 2'b11;

    localparam int MODE_BIT_BEACON = 0;
    localparam int MODE_BIT_ECHO   = 1;

    localparam logic [7:0] ASCII_LC_A        = 8'h61;
    localparam logic [7:0] ASCII_LC_Z        = 8'h7A;
    localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;

    // Lower-case letters map to upper case, every other byte passes through.
    function automatic logic [7:0] to_upper(input logic [7:0] b);
        if (b >= ASCII_LC_A && b <= ASCII_LC_Z) begin
            return b - ASCII_CASE_OFFSET;
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and wrap-bit pointers.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer update; extra MSB distinguishes full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage array, no reset needed since empty gates every read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/serial_beacon_echo.sv
// Byte source/sink for the usb_uart pipelines: periodic fixed beacon message
// plus buffered echo of bytes received from the host.
//
//  state | meaning
//  IDLE  | output empty, choose beacon (priority) or echo
//  MSG   | presenting beacon byte idx, message is atomic
//  WAIT  | inter-message gap counting, echo bytes may go out
//  ECHO  | presenting a copy of the FIFO head, popped on accept
module serial_beacon_echo
    import serial_pkg::*;
#(
    parameter int                   MSG_LEN     = 4,
    parameter logic [8*MSG_LEN-1:0] MSG         = "OK\r\n",
    parameter int                   DELAY_WIDTH = 20,
    parameter int                   FIFO_DEPTH  = 8,
    parameter int                   ECHO_UPPER  = 0
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic [1:0] mode,
    output logic [7:0] uart_in_data,
    output logic       uart_in_valid,
    input  logic       uart_in_ready,
    input  logic [7:0] uart_out_data,
    input  logic       uart_out_valid,
    output logic       uart_out_ready,
    output logic       msg_done,
    output logic       busy
);

    localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [DELAY_WIDTH-1:0] delay_cnt;

    logic       accept;
    logic       wrap;
    logic       push;
    logic       pop;
    logic [7:0] fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] echo_byte;

    // First byte of the message sits in the top byte of MSG.
    function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0] i);
        logic [8*MSG_LEN-1:0] shifted;
        shifted = MSG << (8 * i);
        return shifted[8*MSG_LEN-1 -: 8];
    endfunction

    assign accept    = uart_in_valid && uart_in_ready;
    assign wrap      = (delay_cnt == '1);
    assign echo_byte = (ECHO_UPPER != 0) ? to_upper(fifo_head) : fifo_head;

    // With echo off the host is never stalled and bytes are dropped.
    assign uart_out_ready = reset ? 1'b0 : (mode[MODE_BIT_ECHO] ? !fifo_full : 1'b1);
    assign push           = uart_out_valid && uart_out_ready && mode[MODE_BIT_ECHO];

    // The echo byte stays in the FIFO until the transmit side takes it, so the
    // FIFO depth bounds everything in flight; any valid byte in WAIT is echo.
    assign pop = accept && (state == ST_ECHO || state == ST_WAIT);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_48mhz),
        .rst       (reset),
        .push      (push),
        .push_data (uart_out_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Sequencer: beacon message, gap timer, echo slot and registered outputs.
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            idx           <= '0;
            delay_cnt     <= '0;
            uart_in_data  <= '0;
            uart_in_valid <= 1'b0;
            msg_done      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            msg_done <= 1'b0;
            busy     <= (state == ST_MSG) || !fifo_empty;
            case (state)
                ST_IDLE: begin
                    if (mode[MODE_BIT_BEACON]) begin
                        state         <= ST_MSG;
                        idx           <= '0;
                        uart_in_data  <= msg_byte('0);
                        uart_in_valid <= 1'b1;
                    end else if (!fifo_empty) begin
                        state         <= ST_ECHO;
                        uart_in_data  <= echo_byte;
                        uart_in_valid <= 1'b1;
                    end
                end
                ST_MSG: begin
                    if (accept) begin
                        if (idx == LAST_IDX) begin
                            msg_done      <= 1'b1;
                            delay_cnt     <= '0;
                            uart_in_valid <= 1'b0;
                            state         <= ST_WAIT;
                        end else begin
                            idx          <= idx + 1'b1;
                            uart_in_data <= msg_byte(idx + 1'b1);
                        end
                    end
                end
                ST_WAIT: begin
                    delay_cnt <= delay_cnt + 1'b1;
                    // On wrap the next message starts right away so the output
                    // is quiet for exactly 2**DELAY_WIDTH cycles.
                    if (wrap) begin
                        if (uart_in_valid && !accept) begin
                            state <= ST_ECHO;
                        end else if (mode[MODE_BIT_BEACON]) begin
                            state         <= ST_MSG;
                            idx           <= '0;
                            uart_in_data  <= msg_byte('0);
                            uart_in_valid <= 1'b1;
                        end else begin
                            state         <= ST_IDLE;
                            uart_in_valid <= 1'b0;
                        end
                    end else if (uart_in_valid) begin
                        if (accept) begin
                            uart_in_valid <= 1'b0;
                        end
                    end else if (!fifo_empty) begin
                        uart_in_data  <= echo_byte;
                        uart_in_valid <= 1'b1;
                    end
                end
                ST_ECHO: begin
                    if (accept) begin
                        uart_in_valid <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
